btn_conditioner: RTL and testbench
==================================

Name: btn_conditioner

Overview:
- Per-button input conditioner that sits directly upstream of the game core.
- Takes raw pushbutton levels (btn_in[3:0]) and produces clean, glitch-free signals for the reaction-timer logic:
  - debounced levels
  - single-cycle press pulses
  - single-cycle release pulses
  - long-press pulses
- Each channel has its own 2-flop synchroniser, debounce FSM and counters. All channels are fully independent.

Parameters:
- N_BTN, 4: number of button channels.
- DEBOUNCE_CYC, 500000: consecutive stable synchronised cycles required to accept an edge (10 ms at 50 MHz).
- LONG_CYC, 50000000: cycles in HELD before btn_long fires (1 s at 50 MHz).
- REPEAT_CYC, 10000000: auto-repeat period after a long press (only used with the optional feature).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- btn_in  in  N_BTN  raw asynchronous button levels, active-high.
- btn_level  out  N_BTN  debounced level per channel.
- btn_press  out  N_BTN  1-cycle pulse on an accepted press.
- btn_release  out  N_BTN  1-cycle pulse on an accepted release.
- btn_long  out  N_BTN  1-cycle pulse when a press has been held for LONG_CYC.
- any_press  out  1  OR of btn_press, registered alongside it (same cycle).

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n, and clears everything immediately.
- Reset values:
  - all outputs 0
  - both synchroniser flops 0
  - every FSM in IDLE
  - all counters 0
- Synchroniser: btn_in[i] -> s1[i] -> s2[i]. The FSM sees only s2.
- Counter widths:
  - deb_cnt is $clog2(DEBOUNCE_CYC)+1 bits.
  - hold_cnt is $clog2(LONG_CYC)+1 bits.
  - rep_cnt is $clog2(REPEAT_CYC)+1 bits.
  - No counter ever wraps. hold_cnt saturates at LONG_CYC.
- FSM per channel (states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT):
  - IDLE: btn_level=0. If s2=1: go to PRESS_WAIT, deb_cnt<=1.
  - PRESS_WAIT:
    - If s2=0: go to IDLE, deb_cnt<=0. This is a bounce; no output.
    - Else if deb_cnt==DEBOUNCE_CYC-1: go to HELD; btn_press=1 and btn_level=1 on the next cycle; hold_cnt<=0.
    - Else: deb_cnt++.
  - HELD:
    - If s2=0: go to RELEASE_WAIT, deb_cnt<=1.
    - Else: hold_cnt++ (saturating). When hold_cnt reaches LONG_CYC-1, btn_long pulses once. It pulses only once per press.
  - RELEASE_WAIT:
    - If s2=1: go to HELD with no pulse. hold_cnt keeps its value, so a release glitch does not restart long-press timing.
    - Else if deb_cnt==DEBOUNCE_CYC-1: go to IDLE; btn_release=1 and btn_level=0 on the next cycle.
    - Else: deb_cnt++.
- Latency:
  - btn_in stable high to btn_press high takes exactly DEBOUNCE_CYC+3 clk edges: 2 synchroniser edges + DEBOUNCE_CYC counting edges + 1 output register edge.
  - Release is symmetric.
- Pulse timing:
  - btn_level changes in the same cycle as its press/release pulse.
  - Every pulse lasts exactly 1 cycle.
- Boundary cases:
  - DEBOUNCE_CYC=1: an edge is accepted after 1 stable sample.
  - A bounce shorter than DEBOUNCE_CYC produces no pulses and leaves btn_level unchanged.
  - Simultaneous presses on several channels pulse in the same cycle, and any_press=1 once.
  - Reset mid-press: outputs drop to 0 immediately. A button still held after reset release is re-debounced and produces a fresh btn_press.
  - btn_press and btn_release are never both 1 on the same channel in the same cycle.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Defined:
  - After btn_long fires, rep_cnt counts in HELD.
  - Each time rep_cnt reaches REPEAT_CYC-1, btn_press pulses again and rep_cnt clears.
  - rep_cnt clears on leaving HELD.
  - A glitch into RELEASE_WAIT freezes rep_cnt.
- Undefined:
  - rep_cnt logic is absent.
  - btn_press fires exactly once per accepted press.

Test Plan (DEBOUNCE_CYC=4, LONG_CYC=20, REPEAT_CYC=8):
- Reset, then raise btn_in[2] and hold it -> btn_press[2] high for 1 cycle exactly 7 edges later; btn_level[2]=1 from that cycle; any_press=1 in the same cycle; other channels stay 0.
- btn_in[0] toggled 1,0,1,0 with 2-cycle highs, then held low -> no pulses; btn_level[0] stays 0.
- Hold btn_in[1], then drop it for 2 cycles mid-hold -> no release; a single btn_long[1] pulse 20 cycles after btn_press[1]; a clean release gives btn_release[1] 7 edges after btn_in falls.
- Raise btn_in[0] and btn_in[3] on the same edge -> both btn_press bits pulse in the same cycle; any_press pulses once.
- Assert rst_n=0 while btn_level[2]=1, keep btn_in[2] high, then release reset -> btn_level[2] is 0 immediately; a fresh btn_press[2] 7 edges after rst_n rises.
- With BTN_AUTO_REPEAT_EN, hold btn_in[3] for 60 cycles -> btn_press[3] at the initial accept, then every 8 cycles after btn_long[3]. Without the macro -> exactly one btn_press[3].

Source files
------------

// File: rtl/btn_conditioner.sv
// Per-channel pushbutton conditioner: 2-flop synchroniser, debounce FSM, level and pulse outputs.
// Defining BTN_AUTO_REPEAT_EN adds auto-repeat of btn_press once a long press has fired.
//
// state        | meaning
// IDLE         | released, waiting for the synchronised input to rise
// PRESS_WAIT   | input high, counting stable samples before accepting the press
// HELD         | press accepted, timing the long press (and auto-repeat if enabled)
// RELEASE_WAIT | input low, counting stable samples before accepting the release

module btn_conditioner #(
  parameter int N_BTN        = 4,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int LONG_CYC     = 50000000,
  parameter int REPEAT_CYC   = 10000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic             any_press
);

  localparam int DW = $clog2(DEBOUNCE_CYC) + 1;
  localparam int HW = $clog2(LONG_CYC) + 1;
  localparam logic [DW-1:0] DEB_ONE   = DW'(1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(LONG_CYC);
  // With a single-sample debounce the edge is accepted straight from IDLE/HELD.
  localparam bit DEB_SINGLE = (DEBOUNCE_CYC <= 1);
`ifdef BTN_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYC) + 1;
  localparam logic [RW-1:0] REP_ONE  = RW'(1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYC - 1);
`endif

  if (DEBOUNCE_CYC < 1 || LONG_CYC < 1 || REPEAT_CYC < 1) begin : g_bad_param
    $error("btn_conditioner: cycle parameters must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] s2;
  logic [N_BTN-1:0] press_v;
  logic [N_BTN-1:0] release_v;
  logic [N_BTN-1:0] long_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    state_t        state, state_nxt;
    logic [DW-1:0] deb_cnt, deb_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic          press_c, release_c, long_c;
    logic          press_r, release_r, long_r;
`ifdef BTN_AUTO_REPEAT_EN
    logic [RW-1:0] rep_cnt, rep_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state     <= IDLE;
        deb_cnt   <= '0;
        hold_cnt  <= '0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
        rep_cnt   <= '0;
`endif
      end else begin
        state     <= state_nxt;
        deb_cnt   <= deb_nxt;
        hold_cnt  <= hold_nxt;
        press_r   <= press_c;
        release_r <= release_c;
        long_r    <= long_c;
`ifdef BTN_AUTO_REPEAT_EN
        rep_cnt   <= rep_nxt;
`endif
      end
    end

    always_comb begin
      state_nxt = state;
      deb_nxt   = deb_cnt;
      hold_nxt  = hold_cnt;
      press_c   = 1'b0;
      release_c = 1'b0;
      long_c    = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
      rep_nxt   = rep_cnt;
`endif
      case (state)
        IDLE: begin
`ifdef BTN_AUTO_REPEAT_EN
          rep_nxt = '0;
`endif
          if (s2[i]) begin
            if (DEB_SINGLE) begin
              state_nxt = HELD;
              press_c   = 1'b1;
              hold_nxt  = '0;
              deb_nxt   = '0;
            end else begin
              state_nxt = PRESS_WAIT;
              deb_nxt   = DEB_ONE;
            end
          end
        end
        PRESS_WAIT: begin
          if (!s2[i]) begin
            state_nxt = IDLE;
            deb_nxt   = '0;
          end else if (deb_cnt == DEB_LAST) begin
            state_nxt = HELD;
            press_c   = 1'b1;
            hold_nxt  = '0;
            deb_nxt   = '0;
          end else begin
            deb_nxt = deb_cnt + DEB_ONE;
          end
        end
        HELD: begin
          if (!s2[i]) begin
            if (DEB_SINGLE) begin
              state_nxt = IDLE;
              release_c = 1'b1;
              deb_nxt   = '0;
`ifdef BTN_AUTO_REPEAT_EN
              rep_nxt   = '0;
`endif
            end else begin
              state_nxt = RELEASE_WAIT;
              deb_nxt   = DEB_ONE;
            end
          end else begin
            if (hold_cnt == HOLD_LAST) begin
              long_c   = 1'b1;
              hold_nxt = HOLD_SAT;
            end else if (hold_cnt != HOLD_SAT) begin
              hold_nxt = hold_cnt + HOLD_ONE;
            end
`ifdef BTN_AUTO_REPEAT_EN
            // A saturated hold counter means btn_long has already fired.
            if (hold_cnt == HOLD_SAT) begin
              if (rep_cnt == REP_LAST) begin
                press_c = 1'b1;
                rep_nxt = '0;
              end else begin
                rep_nxt = rep_cnt + REP_ONE;
              end
            end
`endif
          end
        end
        RELEASE_WAIT: begin
          if (s2[i]) begin
            state_nxt = HELD;
            deb_nxt   = '0;
          end else if (deb_cnt == DEB_LAST) begin
            state_nxt = IDLE;
            release_c = 1'b1;
            deb_nxt   = '0;
`ifdef BTN_AUTO_REPEAT_EN
            rep_nxt   = '0;
`endif
          end else begin
            deb_nxt = deb_cnt + DEB_ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
          deb_nxt   = '0;
          hold_nxt  = '0;
        end
      endcase
    end

    assign press_v[i]   = press_r;
    assign release_v[i] = release_r;
    assign long_v[i]    = long_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      btn_long    <= '0;
      any_press   <= 1'b0;
    end else begin
      btn_level   <= (btn_level | press_v) & ~release_v;
      btn_press   <= press_v;
      btn_release <= release_v;
      btn_long    <= long_v;
      any_press   <= |press_v;
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner with DEBOUNCE_CYC=4, LONG_CYC=20, REPEAT_CYC=8.
// Output events are queued by a negedge monitor and matched against scoreboard expectations.

module tb_btn_conditioner;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_in;
  logic [3:0] btn_level, btn_press, btn_release, btn_long;
  logic       any_press;

  btn_conditioner #(
    .N_BTN(4), .DEBOUNCE_CYC(4), .LONG_CYC(20), .REPEAT_CYC(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_long(btn_long), .any_press(any_press)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  press;
    logic [3:0]  rel;
    logic [3:0]  lng;
    logic [3:0]  level;
    logic        any;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         passed = 0;
  logic [3:0] last_level = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // An event is any pulse or any change of the debounced level.
  always @(negedge clk) begin
    if (rst_n && ((btn_press | btn_release | btn_long) != 4'b0 || any_press || btn_level != last_level))
      obs_q.push_back(mk(cyc, btn_press, btn_release, btn_long, btn_level, any_press));
    last_level = btn_level;
  end

  function automatic ev_t mk(int c, logic [3:0] p, logic [3:0] r, logic [3:0] l, logic [3:0] lv, logic a);
    ev_t e;
    e.cyc = 32'(c); e.press = p; e.rel = r; e.lng = l; e.level = lv; e.any = a;
    return e;
  endfunction

  function automatic string fmt(ev_t e);
    return $sformatf("cyc=%0d press=%b rel=%b long=%b level=%b any=%b",
                     e.cyc, e.press, e.rel, e.lng, e.level, e.any);
  endfunction

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    btn_in = 4'b0;
    step(2);
    checks++;
    if ({btn_level, btn_press, btn_release, btn_long, any_press} !== 17'b0)
      $display("FAIL reset_outputs: got %b, want 0", {btn_level, btn_press, btn_release, btn_long, any_press});
    else passed++;
    btn_in = 4'hF;
    step(4);
    checks++;
    if ({btn_level, btn_press, btn_release, btn_long, any_press} !== 17'b0)
      $display("FAIL reset_held_inputs: got %b, want 0", {btn_level, btn_press, btn_release, btn_long, any_press});
    else passed++;
    btn_in = 4'b0;
    step(3);
    rst_n = 1'b1;
    step(10);
    checks++;
    if ({btn_level, btn_press, btn_release, btn_long, any_press} !== 17'b0 || obs_q.size() != 0)
      $display("FAIL reset_release_quiet: got %b events=%0d, want 0 events=0",
               {btn_level, btn_press, btn_release, btn_long, any_press}, obs_q.size());
    else passed++;
    obs_q.delete();
  endtask

  task automatic test_press;
    ev_t e, o;
    int c;
    btn_in[2] = 1'b1; c = cyc;
    exp_q.push_back(mk(c + 7, 4'b0100, 4'b0, 4'b0, 4'b0100, 1'b1));
    step(12);
    btn_in[2] = 1'b0; c = cyc;
    exp_q.push_back(mk(c + 7, 4'b0, 4'b0100, 4'b0, 4'b0000, 1'b0));
    step(12);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) $display("FAIL press_evt: got none, want %s", fmt(e));
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL press_evt: got %s, want %s", fmt(o), fmt(e)); else passed++;
      end
    end
    while (obs_q.size() != 0) begin
      o = obs_q.pop_front(); checks++;
      $display("FAIL press_extra: got %s, want none", fmt(o));
    end
  endtask

  task automatic test_bounce;
    ev_t o;
    btn_in[0] = 1'b1; step(2);
    btn_in[0] = 1'b0; step(2);
    btn_in[0] = 1'b1; step(2);
    btn_in[0] = 1'b0; step(14);
    checks++;
    if (btn_level[0] !== 1'b0) $display("FAIL bounce_level: got %b, want 0", btn_level[0]);
    else passed++;
    while (obs_q.size() != 0) begin
      o = obs_q.pop_front(); checks++;
      $display("FAIL bounce_extra: got %s, want none", fmt(o));
    end
  endtask

  task automatic test_long;
    ev_t e, o;
    int c;
    btn_in[1] = 1'b1; c = cyc;
    exp_q.push_back(mk(c + 7,  4'b0010, 4'b0, 4'b0, 4'b0010, 1'b1));
    exp_q.push_back(mk(c + 27, 4'b0, 4'b0, 4'b0010, 4'b0010, 1'b0));
    step(27);
    btn_in[1] = 1'b0; step(2);
    btn_in[1] = 1'b1; step(3);
    btn_in[1] = 1'b0;
    exp_q.push_back(mk(cyc + 7, 4'b0, 4'b0010, 4'b0, 4'b0000, 1'b0));
    step(12);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) $display("FAIL long_evt: got none, want %s", fmt(e));
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL long_evt: got %s, want %s", fmt(o), fmt(e)); else passed++;
      end
    end
    while (obs_q.size() != 0) begin
      o = obs_q.pop_front(); checks++;
      $display("FAIL long_extra: got %s, want none", fmt(o));
    end
  endtask

  task automatic test_simultaneous;
    ev_t e, o;
    int c;
    btn_in = 4'b1001; c = cyc;
    exp_q.push_back(mk(c + 7, 4'b1001, 4'b0, 4'b0, 4'b1001, 1'b1));
    step(10);
    btn_in = 4'b0000; c = cyc;
    exp_q.push_back(mk(c + 7, 4'b0, 4'b1001, 4'b0, 4'b0000, 1'b0));
    step(12);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) $display("FAIL simul_evt: got none, want %s", fmt(e));
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL simul_evt: got %s, want %s", fmt(o), fmt(e)); else passed++;
      end
    end
    while (obs_q.size() != 0) begin
      o = obs_q.pop_front(); checks++;
      $display("FAIL simul_extra: got %s, want none", fmt(o));
    end
  endtask

  task automatic test_reset_mid;
    ev_t e, o;
    int c;
    btn_in[2] = 1'b1; c = cyc;
    exp_q.push_back(mk(c + 7, 4'b0100, 4'b0, 4'b0, 4'b0100, 1'b1));
    step(10);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({btn_level, btn_press, btn_release, btn_long, any_press} !== 17'b0)
      $display("FAIL reset_mid_outputs: got %b, want 0", {btn_level, btn_press, btn_release, btn_long, any_press});
    else passed++;
    step(3);
    rst_n = 1'b1; c = cyc;
    exp_q.push_back(mk(c + 7, 4'b0100, 4'b0, 4'b0, 4'b0100, 1'b1));
    step(10);
    btn_in[2] = 1'b0; c = cyc;
    exp_q.push_back(mk(c + 7, 4'b0, 4'b0100, 4'b0, 4'b0000, 1'b0));
    step(12);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) $display("FAIL reset_mid_evt: got none, want %s", fmt(e));
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL reset_mid_evt: got %s, want %s", fmt(o), fmt(e)); else passed++;
      end
    end
    while (obs_q.size() != 0) begin
      o = obs_q.pop_front(); checks++;
      $display("FAIL reset_mid_extra: got %s, want none", fmt(o));
    end
  endtask

  task automatic test_repeat;
    ev_t e, o;
    int c;
    btn_in[3] = 1'b1; c = cyc;
    exp_q.push_back(mk(c + 7,  4'b1000, 4'b0, 4'b0, 4'b1000, 1'b1));
    exp_q.push_back(mk(c + 27, 4'b0, 4'b0, 4'b1000, 4'b1000, 1'b0));
`ifdef BTN_AUTO_REPEAT_EN
    for (int k = 0; k < 4; k++)
      exp_q.push_back(mk(c + 35 + 8 * k, 4'b1000, 4'b0, 4'b0, 4'b1000, 1'b1));
`endif
    step(60);
    btn_in[3] = 1'b0;
    exp_q.push_back(mk(c + 67, 4'b0, 4'b1000, 4'b0, 4'b0000, 1'b0));
    step(12);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) $display("FAIL repeat_evt: got none, want %s", fmt(e));
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL repeat_evt: got %s, want %s", fmt(o), fmt(e)); else passed++;
      end
    end
    while (obs_q.size() != 0) begin
      o = obs_q.pop_front(); checks++;
      $display("FAIL repeat_extra: got %s, want none", fmt(o));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    btn_in = 4'b0;
    test_reset();
    test_press();
    test_bounce();
    test_long();
    test_simultaneous();
    test_reset_mid();
    test_repeat();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
